key_scan_arbiter: RTL and testbench



---
 rtl/key_scan_if.sv | 33 +++
 rtl/key_scan_arbiter.sv | 162 ++++++++++++++++
 tb/tb_key_scan_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/key_scan_if.sv
// Key panel signal bundle: raw key levels in, debounced levels, event pulses
// and grant status out. The arbiter connects through the slave modport and
// the panel/user side through the master modport.
interface key_scan_if #(
    parameter int N_KEYS = 4
);
    localparam int IW = $clog2(N_KEYS);

    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] key_state;
    logic [N_KEYS-1:0] press_pulse;
    logic [N_KEYS-1:0] release_pulse;
    logic              busy;
    logic [IW-1:0]     active_idx;

    modport slave (
        input  key_raw,
        output key_state,
        output press_pulse,
        output release_pulse,
        output busy,
        output active_idx
    );

    modport master (
        output key_raw,
        input  key_state,
        input  press_pulse,
        input  release_pulse,
        input  busy,
        input  active_idx
    );
endinterface

// File: rtl/key_scan_arbiter.sv
// Shared-counter key debouncer. Raw keys are synchronized, then a single
// debounce counter is granted round-robin to one mismatching key at a time;
// the key's level commits after DEBOUNCE_MS stable cycles.
// Optional feature macro: KEY_RELEASE_EVT_EN builds the release event pulses;
// without it release_pulse is tied low (key_state still follows releases).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | counter free, searching mismatches from rr_ptr upward
// S_COUNT  | counter granted to active_idx, checking its stable window
// S_COMMIT | window complete, update key_state and emit the event pulse
module key_scan_arbiter #(
    parameter  int N_KEYS      = 4,
    parameter  int DEBOUNCE_MS = 12,
    localparam int IW          = $clog2(N_KEYS)
) (
    input  logic       clk_1KHz,
    input  logic       rst_n,
    key_scan_if.slave  ks
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    localparam logic [4:0] CNT_LAST = 5'(DEBOUNCE_MS - 1);

    state_t            r_state;
    logic [N_KEYS-1:0] r_sync1;
    logic [N_KEYS-1:0] r_sync2;
    logic [N_KEYS-1:0] r_key_state;
    logic [N_KEYS-1:0] r_press;
    logic [IW-1:0]     r_rr_ptr;
    logic [IW-1:0]     r_active_idx;
    logic [4:0]        r_cnt;
    logic              r_busy;

    logic [N_KEYS-1:0] w_mis;
    logic              w_found;
    logic [IW-1:0]     w_cand;
    logic [IW-1:0]     w_grant_idx;
    logic [IW-1:0]     w_next_ptr;
    logic              w_sync_act;
    logic              w_state_act;

    // Index arithmetic modulo N_KEYS, valid for non-power-of-two key counts.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_KEYS) s = s - N_KEYS;
        return IW'(s);
    endfunction

    assign w_mis       = r_sync2 ^ r_key_state;
    assign w_next_ptr  = wrap_add(r_active_idx, 1);
    assign w_sync_act  = r_sync2[r_active_idx];
    assign w_state_act = r_key_state[r_active_idx];

    // Round-robin search: first mismatching key at or above rr_ptr, wrapping.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            w_cand = wrap_add(r_rr_ptr, k);
            if (!w_found && w_mis[w_cand]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    // Two-flop synchronizer per key.
    always_ff @(posedge clk_1KHz or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= ks.key_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef KEY_RELEASE_EVT_EN
    logic [N_KEYS-1:0] r_release;
`endif

    // Grant / count / commit sequencer with registered outputs.
    always_ff @(posedge clk_1KHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_key_state  <= '0;
            r_press      <= '0;
            r_rr_ptr     <= '0;
            r_active_idx <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
`ifdef KEY_RELEASE_EVT_EN
            r_release    <= '0;
`endif
        end else begin
            r_press <= '0;
`ifdef KEY_RELEASE_EVT_EN
            r_release <= '0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_active_idx <= w_grant_idx;
                        r_cnt        <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (!w_mis[r_active_idx]) begin
                        r_rr_ptr <= w_next_ptr;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_COMMIT;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_COMMIT: begin
                    // A bounce landing exactly on this edge commits the old
                    // level again, so a pulse is only raised on a real change.
                    r_key_state[r_active_idx] <= w_sync_act;
                    if (w_sync_act && !w_state_act) begin
                        r_press[r_active_idx] <= 1'b1;
                    end
`ifdef KEY_RELEASE_EVT_EN
                    if (!w_sync_act && w_state_act) begin
                        r_release[r_active_idx] <= 1'b1;
                    end
`endif
                    r_rr_ptr <= w_next_ptr;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ks.key_state   = r_key_state;
    assign ks.press_pulse = r_press;
    assign ks.busy        = r_busy;
    assign ks.active_idx  = r_active_idx;
`ifdef KEY_RELEASE_EVT_EN
    assign ks.release_pulse = r_release;
`else
    assign ks.release_pulse = '0;
`endif

endmodule

// File: tb/tb_key_scan_arbiter.sv
module tb_key_scan_arbiter;
    localparam int N = 4;
    localparam int D = 12;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    key_scan_if #(.N_KEYS(N)) ks_if ();

    key_scan_arbiter #(.N_KEYS(N), .DEBOUNCE_MS(D)) dut (
        .clk_1KHz (clk),
        .rst_n    (rst_n),
        .ks       (ks_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: a granted key commits D+1 edges after its grant edge
    // unless its synchronized level stops differing from the committed level
    // at any of the D edges in between.
    logic [N-1:0] m_s1, m_s2, m_state, m_press, m_rel;
    int           m_rr, m_idx, m_age;
    bit           m_busy;

    always @(posedge clk or negedge rst_n) begin
        logic [N-1:0] mis;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_state = '0; m_press = '0; m_rel = '0;
            m_rr = 0; m_idx = 0; m_age = 0; m_busy = 0;
        end else begin
            mis     = m_s2 ^ m_state;
            m_press = '0;
            m_rel   = '0;
            if (!m_busy) begin
                for (int k = 0; k < N; k++) begin
                    if (!m_busy && mis[(m_rr + k) % N]) begin
                        m_idx  = (m_rr + k) % N;
                        m_age  = 0;
                        m_busy = 1;
                    end
                end
            end else begin
                m_age++;
                if (m_age == D + 1) begin
                    if (m_s2[m_idx] && !m_state[m_idx]) m_press[m_idx] = 1'b1;
`ifdef KEY_RELEASE_EVT_EN
                    if (!m_s2[m_idx] && m_state[m_idx]) m_rel[m_idx] = 1'b1;
`endif
                    m_state[m_idx] = m_s2[m_idx];
                    m_rr   = (m_idx + 1) % N;
                    m_busy = 0;
                end else if (!mis[m_idx]) begin
                    m_rr   = (m_idx + 1) % N;
                    m_busy = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = ks_if.key_raw;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("key_state", 32'(ks_if.key_state), 32'(m_state));
            chk("press_pulse", 32'(ks_if.press_pulse), 32'(m_press));
            chk("release_pulse", 32'(ks_if.release_pulse), 32'(m_rel));
            chk("busy", 32'(ks_if.busy), 32'(m_busy));
            chk("active_idx", 32'(ks_if.active_idx), 32'(m_idx));
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [N-1:0] rel_exp;

    initial begin
`ifdef KEY_RELEASE_EVT_EN
        rel_exp = 4'b0010;
`else
        rel_exp = 4'b0000;
`endif
        rst_n = 1'b0;
        ks_if.key_raw = '0;
        wait_n(3);
        chk("rst_key_state", 32'(ks_if.key_state), 0);
        chk("rst_busy", 32'(ks_if.busy), 0);
        chk("rst_active_idx", 32'(ks_if.active_idx), 0);

        // Clean press of key 0.
        #1 rst_n = 1'b1; ks_if.key_raw = 4'b0001;
        wait_n(2);  chk("clean_busy_e2", 32'(ks_if.busy), 0);
        wait_n(1);  chk("clean_busy_e3", 32'(ks_if.busy), 1);
                    chk("clean_idx_e3", 32'(ks_if.active_idx), 0);
        wait_n(12); chk("clean_press_e15", 32'(ks_if.press_pulse), 0);
                    chk("clean_busy_e15", 32'(ks_if.busy), 1);
        wait_n(1);  chk("clean_press_e16", 32'(ks_if.press_pulse), 4'b0001);
                    chk("clean_state_e16", 32'(ks_if.key_state), 4'b0001);
                    chk("clean_busy_e16", 32'(ks_if.busy), 0);
        wait_n(1);  chk("clean_press_e17", 32'(ks_if.press_pulse), 0);
        #1 ks_if.key_raw = '0;
        wait_n(20);

        // Bouncy press of key 2.
        for (int p = 0; p < 6; p++) begin
            #1 ks_if.key_raw = (p % 2 == 0) ? 4'b0100 : 4'b0000;
            wait_n(3);
        end
        chk("bounce_no_commit", 32'(ks_if.key_state), 0);
        #1 ks_if.key_raw = 4'b0100;
        wait_n(15); chk("bounce_press_e15", 32'(ks_if.press_pulse), 0);
        wait_n(1);  chk("bounce_press_e16", 32'(ks_if.press_pulse), 4'b0100);
        wait_n(3);

        // All keys at once, served 0..3, 14 cycles apart.
        #1 rst_n = 1'b0; ks_if.key_raw = '0;
        wait_n(2);
        #1 rst_n = 1'b1; ks_if.key_raw = 4'b1111;
        wait_n(16); chk("all_press0", 32'(ks_if.press_pulse), 4'b0001);
        wait_n(14); chk("all_press1", 32'(ks_if.press_pulse), 4'b0010);
        wait_n(14); chk("all_press2", 32'(ks_if.press_pulse), 4'b0100);
        wait_n(14); chk("all_press3", 32'(ks_if.press_pulse), 4'b1000);
                    chk("all_state", 32'(ks_if.key_state), 4'b1111);
        wait_n(2);
        #1 ks_if.key_raw = 4'b0110;
        wait_n(16); chk("fair_first_key0", 32'(ks_if.key_state), 4'b1110);
        wait_n(14); chk("fair_then_key3", 32'(ks_if.key_state), 4'b0110);

        // Round-robin wrap: after a key-2 commit, keys 3 and 0 change together.
        wait_n(2);
        #1 ks_if.key_raw = 4'b0010;
        wait_n(16); chk("wrap_key2_rel", 32'(ks_if.key_state), 4'b0010);
        wait_n(2);
        #1 ks_if.key_raw = 4'b1011;
        wait_n(3);  chk("wrap_idx_first", 32'(ks_if.active_idx), 3);
                    chk("wrap_busy_first", 32'(ks_if.busy), 1);
        wait_n(13); chk("wrap_state_k3", 32'(ks_if.key_state), 4'b1010);
        wait_n(1);  chk("wrap_idx_second", 32'(ks_if.active_idx), 0);
        wait_n(13); chk("wrap_state_k0", 32'(ks_if.key_state), 4'b1011);

        // Release of key 1.
        wait_n(2);
        #1 ks_if.key_raw = 4'b1001;
        wait_n(16); chk("rel_pulse", 32'(ks_if.release_pulse), 32'(rel_exp));
                    chk("rel_state", 32'(ks_if.key_state), 4'b1001);
        wait_n(1);  chk("rel_pulse_after", 32'(ks_if.release_pulse), 0);

        // Reset in the middle of a count window.
        wait_n(2);
        #1 rst_n = 1'b0; ks_if.key_raw = '0;
        wait_n(2);
        #1 rst_n = 1'b1; ks_if.key_raw = 4'b0001;
        wait_n(8);  chk("midrst_busy_before", 32'(ks_if.busy), 1);
        #1 rst_n = 1'b0;
        #1 chk("midrst_state", 32'(ks_if.key_state), 0);
           chk("midrst_busy", 32'(ks_if.busy), 0);
           chk("midrst_idx", 32'(ks_if.active_idx), 0);
           chk("midrst_press", 32'(ks_if.press_pulse), 0);
        wait_n(2);
        #1 rst_n = 1'b1;
        wait_n(15); chk("midrst_press_e15", 32'(ks_if.press_pulse), 0);
                    chk("midrst_busy_e15", 32'(ks_if.busy), 1);
        wait_n(1);  chk("midrst_press_e16", 32'(ks_if.press_pulse), 4'b0001);

        // Randomized traffic with occasional asynchronous resets.
        for (int it = 0; it < 300; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            #1;
            if (r < 5)
                ks_if.key_raw[$urandom_range(0, N - 1)] ^= 1'b1;
            else if (r < 7)
                ks_if.key_raw ^= N'($urandom_range(0, (1 << N) - 1));
            if (it % 97 == 50) begin
                #2 rst_n = 1'b0;
                wait_n(1);
                #1 rst_n = 1'b1;
            end
            wait_n(int'($urandom_range(1, 25)));
        end
        #1 ks_if.key_raw = '0;
        wait_n(80);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
